// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants for the serial add/subtract unit.
//               - OP_ADD / OP_SUB : encodings of the op input
//               - ST_IDLE / ST_RUN / ST_DONE : controller state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder
// Description : Combinational CHUNK-bit ripple slice.
//               Ports:
//                 x, y   in  CHUNK  slice operands
//                 ci     in  1      slice carry-in
//                 sum    out CHUNK  slice sum
//                 co     out 1      carry out of the top bit
//                 c_msb  out 1      carry into the top bit (for overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  // The low CHUNK-1 bits are added separately so the carry into the top
  // bit is visible; signed overflow needs it on the most-significant slice.
  generate
    if (CHUNK > 1) begin : g_multi_bit
      assign {c_msb, sum[CHUNK-2:0]} = {1'b0, x[CHUNK-2:0]}
                                     + {1'b0, y[CHUNK-2:0]}
                                     + {{(CHUNK-1){1'b0}}, ci};
    end else begin : g_single_bit
      assign c_msb = ci;
    end
  endgenerate

  assign {co, sum[CHUNK-1]} = {1'b0, x[CHUNK-1]} + {1'b0, y[CHUNK-1]} + {1'b0, c_msb};

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Multi-cycle WIDTH-bit add/subtract unit. One CHUNK-bit slice
//               adder is reused for WIDTH/CHUNK cycles. Subtraction is done as
//               a + ~b + ~bin, with borrow reported on cout.
//               Ports:
//                 clk, rst            clock / synchronous active-high reset
//                 in_valid, in_ready  operand handshake (ready in IDLE only)
//                 a, b, op, cin       operands, 0=ADD 1=SUB, carry/borrow in
//                 out_valid,out_ready result handshake
//                 s, cout, ovf, zero  result and flags (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int             NCHUNK     = WIDTH / CHUNK;
  localparam int             CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("serial_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;      // shifted right one slice per RUN cycle
  logic [WIDTH-1:0]   b_q,     b_d;      // already inverted for SUB
  logic               carry_q, carry_d;
  logic               op_q,    op_d;
  logic [WIDTH-1:0]   s_q,     s_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;
  logic               zero_q,  zero_d;

  // --------------------------------------------------------------------------
  // Shared slice adder
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] slice_sum;
  logic             slice_co;
  logic             slice_c_msb;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .x     (a_q[CHUNK-1:0]),
    .y     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // Result is assembled by shifting each new slice in from the top, so after
  // NCHUNK cycles slice 0 has arrived at the bottom.
  logic [WIDTH-1:0] sum_ext;
  logic [WIDTH-1:0] s_shift;

  always_comb begin
    sum_ext                = '0;
    sum_ext[CHUNK-1:0]     = slice_sum;
    s_shift                = (s_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)               state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CHUNK)    state_d = ST_DONE;
      ST_DONE: if (out_ready)              state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    op_d    = op_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b   : b;
          carry_d = (op == OP_SUB) ? ~cin : cin;
          op_d    = op;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice_co;
        s_d     = s_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          // Final slice: the adder carry is inverted back into a borrow for SUB.
          cout_d = (op_q == OP_SUB) ? ~slice_co : slice_co;
          ovf_d  = slice_c_msb ^ slice_co;
          zero_d = (s_shift == '0);
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire
